regfile_scoreboard: RTL and testbench

//  Parametrised register file for the MIPS datapath: 2 async read ports, 1 sync write port, R0 hardwired to 0.

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write port and R0 tied to zero.
// A per-register busy scoreboard tracks pending writes between issue and writeback for the stall logic.
module regfile_scoreboard #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_register_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic [ADDR_W-1:0] read_register_2,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_register,
    output logic              busy_1,
    output logic              busy_2,
    output logic              wr_zero_err
);

    localparam int NREGS   = 1 << ADDR_W;
    localparam bit BYP_EN  = (BYPASS != 0);
    localparam bit INIT_EN = (INIT_INDEX != 0);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              wr_zero_err_q;
    logic              wr_zero_err_d;

    logic wr_nonzero;
    logic wr_hit_1;
    logic wr_hit_2;

    assign wr_nonzero = RegWrite && (write_register != '0);
    assign wr_hit_1   = wr_nonzero && (write_register == read_register_1);
    assign wr_hit_2   = wr_nonzero && (write_register == read_register_2);

    // Writeback clears first so that a same-cycle issue to the same register leaves it busy.
    always_comb begin
        regs_d        = regs_q;
        busy_d        = busy_q;
        wr_zero_err_d = RegWrite && (write_register == '0);
        if (wr_nonzero) begin
            regs_d[write_register] = write_data;
        end
        if (RegWrite) begin
            busy_d[write_register] = 1'b0;
        end
        if (issue_valid && (issue_register != '0)) begin
            busy_d[issue_register] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= INIT_EN ? DATA_W'(i) : '0;
            end
            busy_q        <= '0;
            wr_zero_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            wr_zero_err_q <= wr_zero_err_d;
        end
    end

    always_comb begin
        read_data_1 = '0;
        busy_1      = 1'b0;
        if (read_register_1 != '0) begin
            read_data_1 = (BYP_EN && wr_hit_1) ? write_data : regs_q[read_register_1];
            busy_1      = busy_q[read_register_1] && !(BYP_EN && wr_hit_1);
        end
    end

    always_comb begin
        read_data_2 = '0;
        busy_2      = 1'b0;
        if (read_register_2 != '0) begin
            read_data_2 = (BYP_EN && wr_hit_2) ? write_data : regs_q[read_register_2];
            busy_2      = busy_q[read_register_2] && !(BYP_EN && wr_hit_2);
        end
    end

    assign wr_zero_err = wr_zero_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a randomized run
// checked against an array-based reference model of the register file and busy table.
module tb_regfile_scoreboard;

    localparam int DW     = 16;
    localparam int AW     = 3;
    localparam int NR     = 1 << AW;
    localparam int BYP    = 1;
    localparam int INITIX = 1;

    logic          clk;
    logic          rst;
    logic          RegWrite;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_register_1;
    logic [DW-1:0] read_data_1;
    logic [AW-1:0] read_register_2;
    logic [DW-1:0] read_data_2;
    logic          issue_valid;
    logic [AW-1:0] issue_register;
    logic          busy_1;
    logic          busy_2;
    logic          wr_zero_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    logic [0:0]    exp_q [$];

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .BYPASS(BYP), .INIT_INDEX(INITIX)
    ) dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_register(write_register),
        .write_data(write_data), .read_register_1(read_register_1), .read_data_1(read_data_1),
        .read_register_2(read_register_2), .read_data_2(read_data_2), .issue_valid(issue_valid),
        .issue_register(issue_register), .busy_1(busy_1), .busy_2(busy_2), .wr_zero_err(wr_zero_err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (BYP != 0 && RegWrite && write_register == r) return write_data;
        return m_regs[r];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        if (BYP != 0 && RegWrite && write_register == r) return 1'b0;
        return m_busy[r];
    endfunction

    task automatic idle_inputs();
        RegWrite = 0; write_register = 0; write_data = 0;
        issue_valid = 0; issue_register = 0;
    endtask

    // Advance one clock: update the model from the inputs the DUT samples, then check the error pulse.
    task automatic tick();
        logic e;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = (INITIX != 0) ? DW'(i) : '0;
                m_busy[i] = 0;
            end
            exp_q.push_back(1'b0);
        end else begin
            if (RegWrite && write_register != 0) m_regs[write_register] = write_data;
            if (RegWrite) m_busy[write_register] = 0;
            if (issue_valid && issue_register != 0) m_busy[issue_register] = 1;
            exp_q.push_back(RegWrite && write_register == 0);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (wr_zero_err !== e) begin
            tests_failed++;
            $display("FAIL wr_zero_err: got %b expected %b at %0t", wr_zero_err, e, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); read_register_1 = 5; read_register_2 = 0;
        tick();
        rst = 0; #1;
        tests_run++;
        if (read_data_1 !== 16'h0005) begin
            tests_failed++; $display("FAIL reset_r5: got %h expected %h", read_data_1, 16'h0005);
        end
        tests_run++;
        if (read_data_2 !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_r0: got %h expected %h", read_data_2, 16'h0000);
        end
        tests_run++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b%b expected 00", busy_1, busy_2);
        end
        tests_run++;
        if (wr_zero_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b expected 0", wr_zero_err);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp_same;
        read_register_1 = 3; read_register_2 = 3;
        RegWrite = 1; write_register = 3; write_data = 16'hBEEF;
        exp_same = (BYP != 0) ? 16'hBEEF : 16'h0003;
        #1;
        tests_run++;
        if (read_data_1 !== exp_same) begin
            tests_failed++; $display("FAIL write_same_cycle: got %h expected %h", read_data_1, exp_same);
        end
        tick();
        idle_inputs(); #1;
        tests_run++;
        if (read_data_1 !== 16'hBEEF || read_data_2 !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL write_next_cycle: got %h/%h expected beef/beef", read_data_1, read_data_2);
        end
    endtask

    task automatic test_r0_protect();
        read_register_1 = 0;
        RegWrite = 1; write_register = 0; write_data = 16'hFFFF;
        tick();
        tests_run++;
        if (wr_zero_err !== 1'b1) begin
            tests_failed++; $display("FAIL r0_err_pulse: got %b expected 1", wr_zero_err);
        end
        idle_inputs(); #1;
        tests_run++;
        if (read_data_1 !== 16'h0000) begin
            tests_failed++; $display("FAIL r0_read: got %h expected 0000", read_data_1);
        end
        tick();
        tests_run++;
        if (wr_zero_err !== 1'b0) begin
            tests_failed++; $display("FAIL r0_err_one_cycle: got %b expected 0", wr_zero_err);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_register = 4; read_register_1 = 4;
        tick();
        idle_inputs(); #1;
        tests_run++;
        if (busy_1 !== 1'b1) begin
            tests_failed++; $display("FAIL sb_busy_set: got %b expected 1", busy_1);
        end
        RegWrite = 1; write_register = 4; write_data = 16'h1234; #1;
        tests_run++;
        if (busy_1 !== ((BYP != 0) ? 1'b0 : 1'b1)) begin
            tests_failed++; $display("FAIL sb_busy_bypass: got %b expected %b", busy_1, (BYP == 0));
        end
        tests_run++;
        if (read_data_1 !== ((BYP != 0) ? 16'h1234 : 16'h0004)) begin
            tests_failed++; $display("FAIL sb_data_bypass: got %h", read_data_1);
        end
        tick();
        idle_inputs(); #1;
        tests_run++;
        if (busy_1 !== 1'b0 || read_data_1 !== 16'h1234) begin
            tests_failed++; $display("FAIL sb_cleared: got busy %b data %h expected 0 1234", busy_1, read_data_1);
        end
    endtask

    task automatic test_collision();
        issue_valid = 1; issue_register = 6; read_register_2 = 6;
        tick();
        RegWrite = 1; write_register = 6; write_data = 16'h5A5A;
        issue_valid = 1; issue_register = 6;
        tick();
        idle_inputs(); #1;
        tests_run++;
        if (busy_2 !== 1'b1) begin
            tests_failed++; $display("FAIL collision_busy: got %b expected 1", busy_2);
        end
        tests_run++;
        if (read_data_2 !== 16'h5A5A) begin
            tests_failed++; $display("FAIL collision_data: got %h expected 5a5a", read_data_2);
        end
        // second issue to an already busy register does not count; one writeback clears it
        issue_valid = 1; issue_register = 6;
        tick();
        idle_inputs(); RegWrite = 1; write_register = 6; write_data = 16'h0606;
        tick();
        idle_inputs(); #1;
        tests_run++;
        if (busy_2 !== 1'b0) begin
            tests_failed++; $display("FAIL collision_single_clear: got %b expected 0", busy_2);
        end
    endtask

    task automatic test_reset_midop();
        issue_valid = 1; issue_register = 2;
        tick();
        issue_register = 7;
        tick();
        idle_inputs(); RegWrite = 1; write_register = 2; write_data = 16'hAAAA;
        tick();
        rst = 1; RegWrite = 1; write_register = 7; write_data = 16'h7777;
        issue_valid = 1; issue_register = 3;
        tick();
        rst = 0; idle_inputs(); read_register_1 = 2; read_register_2 = 7; #1;
        tests_run++;
        if (read_data_1 !== 16'h0002 || read_data_2 !== 16'h0007) begin
            tests_failed++;
            $display("FAIL midop_data: got %h/%h expected 0002/0007", read_data_1, read_data_2);
        end
        tests_run++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            tests_failed++; $display("FAIL midop_busy: got %b%b expected 00", busy_1, busy_2);
        end
        read_register_1 = 3; #1;
        tests_run++;
        if (busy_1 !== 1'b0) begin
            tests_failed++; $display("FAIL midop_issue_dropped: got %b expected 0", busy_1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 79) == 0);
            RegWrite        = ($urandom_range(0, 2) == 0);
            write_register  = AW'($urandom_range(0, NR - 1));
            write_data      = DW'($urandom);
            issue_valid     = ($urandom_range(0, 2) == 0);
            issue_register  = AW'($urandom_range(0, NR - 1));
            read_register_1 = AW'($urandom_range(0, NR - 1));
            read_register_2 = ($urandom_range(0, 3) == 0) ? read_register_1 : AW'($urandom_range(0, NR - 1));
            #1;
            tests_run++;
            if (read_data_1 !== exp_read(read_register_1) || read_data_2 !== exp_read(read_register_2)) begin
                tests_failed++;
                $display("FAIL rand_read: r%0d=%h r%0d=%h expected %h %h", read_register_1, read_data_1,
                         read_register_2, read_data_2, exp_read(read_register_1), exp_read(read_register_2));
            end
            tests_run++;
            if (busy_1 !== exp_busy(read_register_1) || busy_2 !== exp_busy(read_register_2)) begin
                tests_failed++;
                $display("FAIL rand_busy: got %b%b expected %b%b", busy_1, busy_2,
                         exp_busy(read_register_1), exp_busy(read_register_2));
            end
            tick();
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        rst = 1; idle_inputs(); read_register_1 = 0; read_register_2 = 0;
        test_reset();
        test_write_read();
        test_r0_protect();
        test_scoreboard();
        test_collision();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
